// File: rtl/smallseg_pkg.sv
// Shared definitions for the small-segment rule-table update engine:
// entry field positions, the empty-slot marker, status and op codes, FSM states.
package smallseg_pkg;

   localparam int unsigned ENTRY_W    = 171;
   localparam int unsigned ID_W       = 11;
   localparam int unsigned RULEID_MSB = 21;
   localparam int unsigned RULEID_LSB = 11;
   localparam int unsigned INDEX_MSB  = 10;
   localparam int unsigned INDEX_LSB  = 0;

   localparam logic [ID_W-1:0] EMPTY_ID = 11'h7FF;

   typedef enum logic [2:0] {
      ST_OK        = 3'd0,
      ST_FULL      = 3'd1,
      ST_NOT_FOUND = 3'd2,
      ST_DUP       = 3'd3,
      ST_BAD_ID    = 3'd4
   } status_e;

   typedef enum logic {
      OP_INSERT = 1'b0,
      OP_DELETE = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_WRITE,
      S_RESP
   } state_e;

   // Pattern stored into a slot freed by delete: only ruleID and index are non-zero.
   function automatic logic [ENTRY_W-1:0] empty_entry(input logic [ID_W-1:0] slot);
      logic [ENTRY_W-1:0] e;
      e = '0;
      e[RULEID_MSB:RULEID_LSB] = EMPTY_ID;
      e[INDEX_MSB:INDEX_LSB]   = slot;
      return e;
   endfunction

endpackage

// File: rtl/smallseg_update_ctrl.sv
// Insert/delete engine for one small-segment rule table: scans the table for a
// duplicate, match or free slot through the memory's addr/we/din/dout, then writes.
module smallseg_update_ctrl
   import smallseg_pkg::*;
#(
   parameter int SUBSET_NUM       = 0,
   parameter int TABLE_NUM        = 0,
   parameter int TABLE_ENTRY_SIZE = 1738
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_op,
   input  logic [ENTRY_W-1:0] req_rule,
   output logic               rsp_valid,
   output logic [2:0]         rsp_status,
   output logic [ID_W-1:0]    rsp_addr,
   output logic [ID_W-1:0]    tbl_addr,
   output logic               tbl_we,
   output logic [ENTRY_W-1:0] tbl_din,
   input  logic [ENTRY_W-1:0] tbl_dout
);

   if (SUBSET_NUM < 0 || SUBSET_NUM > 3 || TABLE_NUM < 0 || TABLE_NUM > 9 ||
       TABLE_ENTRY_SIZE < 0 || TABLE_ENTRY_SIZE > 2047) begin : g_bad_params
      $error("smallseg_update_ctrl: parameter out of range");
   end

   localparam logic [ID_W-1:0] LAST_ADDR = 11'(TABLE_ENTRY_SIZE);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [ENTRY_W-1:0] rule_q, rule_d;
   logic [ID_W-1:0]    cmp_q, cmp_d;
   logic               cmp_vld_q, cmp_vld_d;
   logic [ID_W-1:0]    free_q, free_d;
   logic               free_vld_q, free_vld_d;
   logic [ID_W-1:0]    tbl_addr_q, tbl_addr_d;
   logic               tbl_we_q, tbl_we_d;
   logic [ENTRY_W-1:0] tbl_din_q, tbl_din_d;
   logic               rsp_valid_q, rsp_valid_d;
   status_e            rsp_status_q, rsp_status_d;
   logic [ID_W-1:0]    rsp_addr_q, rsp_addr_d;
   logic               req_ready_q, req_ready_d;

   logic [ID_W-1:0]    dout_id;
   logic               id_hit;
   logic               slot_empty;
   logic               free_vld_now;
   logic [ID_W-1:0]    free_now;

   logic unused_bits;
   assign unused_bits = ^{tbl_dout[ENTRY_W-1:RULEID_MSB+1], tbl_dout[INDEX_MSB:INDEX_LSB],
                          rule_q[INDEX_MSB:INDEX_LSB]};

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rule_d       = rule_q;
      cmp_d        = cmp_q;
      cmp_vld_d    = cmp_vld_q;
      free_d       = free_q;
      free_vld_d   = free_vld_q;
      tbl_addr_d   = tbl_addr_q;
      tbl_we_d     = 1'b0;
      tbl_din_d    = tbl_din_q;
      rsp_valid_d  = 1'b0;
      rsp_status_d = rsp_status_q;
      rsp_addr_d   = rsp_addr_q;
      req_ready_d  = req_ready_q;

      // cmp_q is the address whose read data is on tbl_dout this cycle.
      dout_id    = tbl_dout[RULEID_MSB:RULEID_LSB];
      id_hit     = cmp_vld_q && (dout_id == rule_q[RULEID_MSB:RULEID_LSB]);
      slot_empty = cmp_vld_q && (dout_id == EMPTY_ID);

      free_vld_now = free_vld_q;
      free_now     = free_q;
      if (op_q == OP_INSERT && slot_empty && !free_vld_q) begin
         free_vld_now = 1'b1;
         free_now     = cmp_q;
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               op_d        = op_e'(req_op);
               rule_d      = req_rule;
               req_ready_d = 1'b0;
               cmp_vld_d   = 1'b0;
               free_vld_d  = 1'b0;
               free_d      = '0;
               if (req_rule[RULEID_MSB:RULEID_LSB] == EMPTY_ID) begin
                  state_d      = S_RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = ST_BAD_ID;
                  rsp_addr_d   = '0;
               end else begin
                  state_d    = S_SCAN;
                  tbl_addr_d = '0;
               end
            end
         end
         S_SCAN, S_DRAIN: begin
            free_vld_d = free_vld_now;
            free_d     = free_now;
            cmp_vld_d  = 1'b1;
            cmp_d      = tbl_addr_q;
            if (state_q == S_SCAN) begin
               if (tbl_addr_q == LAST_ADDR) state_d = S_DRAIN;
               else                         tbl_addr_d = tbl_addr_q + 11'd1;
            end
            if (id_hit) begin
               rsp_addr_d = cmp_q;
               if (op_q == OP_INSERT) begin
                  state_d      = S_RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = ST_DUP;
               end else begin
                  state_d      = S_WRITE;
                  tbl_we_d     = 1'b1;
                  tbl_addr_d   = cmp_q;
                  tbl_din_d    = empty_entry(cmp_q);
                  rsp_status_d = ST_OK;
               end
            end else if (state_q == S_DRAIN) begin
               if (op_q == OP_INSERT && free_vld_now) begin
                  state_d      = S_WRITE;
                  tbl_we_d     = 1'b1;
                  tbl_addr_d   = free_now;
                  tbl_din_d    = {rule_q[ENTRY_W-1:INDEX_MSB+1], free_now};
                  rsp_status_d = ST_OK;
                  rsp_addr_d   = free_now;
               end else begin
                  state_d      = S_RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = (op_q == OP_INSERT) ? ST_FULL : ST_NOT_FOUND;
                  rsp_addr_d   = '0;
               end
            end
         end
         S_WRITE: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_INSERT;
         rule_q       <= '0;
         cmp_q        <= '0;
         cmp_vld_q    <= 1'b0;
         free_q       <= '0;
         free_vld_q   <= 1'b0;
         tbl_addr_q   <= '0;
         tbl_we_q     <= 1'b0;
         tbl_din_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= ST_OK;
         rsp_addr_q   <= '0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rule_q       <= rule_d;
         cmp_q        <= cmp_d;
         cmp_vld_q    <= cmp_vld_d;
         free_q       <= free_d;
         free_vld_q   <= free_vld_d;
         tbl_addr_q   <= tbl_addr_d;
         tbl_we_q     <= tbl_we_d;
         tbl_din_q    <= tbl_din_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_addr_q   <= rsp_addr_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign rsp_addr   = rsp_addr_q;
   assign tbl_addr   = tbl_addr_q;
   assign tbl_we     = tbl_we_q;
   assign tbl_din    = tbl_din_q;

endmodule
